input_conditioner: RTL

Parametrised per-channel input conditioner for the DE1 board's push buttons and slide switches, sitting between the raw pad inputs and all user logic. For each channel it synchronises the pad into the CLOCK_50 domain and debounces it over a configurable hold time. It then presents four outputs per channel: a clean active-high level, single-cycle rise and fall pulses, and an optional toggle latch. It replaces direct wiring of BUTTONS and SW to LEDs and logic.

---
 rtl/input_conditioner_pkg.sv | 19 +
 rtl/input_conditioner_if.sv | 28 ++
 rtl/input_conditioner_debounce_channel.sv | 86 ++++++++
 rtl/input_conditioner.sv | 49 ++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants, per-channel output record and counter sizing for input_conditioner.
package input_conditioner_pkg;

    localparam int DEBOUNCE_20MS_AT_50MHZ = 1000000;
    localparam int DEBOUNCE_SIM           = 8;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic toggle;
    } chan_out_t;

    // Width that holds 0..cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pad-side and user-side signal bundle of input_conditioner; master drives RAW, slave is the conditioner.
interface input_conditioner_if #(
    parameter int CHANNELS = 4
);

    logic [CHANNELS-1:0] RAW;
    logic [CHANNELS-1:0] LEVEL;
    logic [CHANNELS-1:0] RISE;
    logic [CHANNELS-1:0] FALL;
    logic [CHANNELS-1:0] TOGGLE;

    modport master (
        output RAW,
        input  LEVEL,
        input  RISE,
        input  FALL,
        input  TOGGLE
    );

    modport slave (
        input  RAW,
        output LEVEL,
        output RISE,
        output FALL,
        output TOGGLE
    );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioner channel: synchroniser, saturating debounce counter, edge pulses, toggle latch.
// Toggle latch is built only when INPUT_CONDITIONER_TOGGLE_EN is defined; otherwise TOGGLE is 0.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int SYNC_STAGES     = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      din,
    output chan_out_t dout
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sample;
    logic                   toggle_out;

    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // The sample has differed for DEBOUNCE_CYCLES consecutive clocks: accept it.
            level_d = sample;
            cnt_d   = '0;
            rise_d  = sample;
            fall_d  = ~sample;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef INPUT_CONDITIONER_TOGGLE_EN
    logic toggle_q, toggle_d;

    // Flips the clock after the RISE pulse, so it trails LEVEL by one cycle.
    always_comb begin
        toggle_d = toggle_q ^ rise_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign toggle_out = toggle_q;
`else
    assign toggle_out = 1'b0;
`endif

    assign dout = '{level: level_q, rise: rise_q, fall: fall_q, toggle: toggle_out};

endmodule

// File: rtl/input_conditioner.sv
// Per-channel input conditioner for DE1 buttons/switches: polarity fix, then one debounce_channel per bit.
// Optional toggle outputs are controlled by INPUT_CONDITIONER_TOGGLE_EN.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_AT_50MHZ,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input_conditioner_if.slave  bus
);

    logic [CHANNELS-1:0] raw_act;
    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;
    logic [CHANNELS-1:0] toggle_w;

    // Everything downstream of this inversion is active-high.
    assign raw_act = (ACTIVE_LOW != 0) ? ~bus.RAW : bus.RAW;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        chan_out_t ch_out;

        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk   (CLOCK_50),
            .rst_n (RESET_N),
            .din   (raw_act[i]),
            .dout  (ch_out)
        );

        assign level_w[i]  = ch_out.level;
        assign rise_w[i]   = ch_out.rise;
        assign fall_w[i]   = ch_out.fall;
        assign toggle_w[i] = ch_out.toggle;
    end

    assign bus.LEVEL  = level_w;
    assign bus.RISE   = rise_w;
    assign bus.FALL   = fall_w;
    assign bus.TOGGLE = toggle_w;

endmodule
